div_arbiter: RTL and testbench

- Sequences and shares the single 5-bit restoring divider between two requesters.
- Accepts dividend/divisor pairs from each requester and arbitrates round-robin.
- Serialises the operands onto the divider's bus_in with a start pulse, waits for done, then collects quotient and remainder from bus_out.
- Returns the result with the zero/overflow flags and a per-requester one-cycle response pulse.
- Sits between the divider top level and its two client blocks.

---
 rtl/div_arb_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 23 ++
 rtl/div_arbiter.sv | 158 +++++++++++++++
 tb/tb_div_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/div_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : div_arb_pkg
// Brief    : State encoding, default widths and grant helper for div_arbiter.
// Revision : 1.0
// ============================================================================
package div_arb_pkg;

  localparam int W_DEF       = 5;
  localparam int TIMEOUT_DEF = 31;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_LOAD_B = 3'd2;
  localparam logic [2:0] ST_WAIT   = 3'd3;
  localparam logic [2:0] ST_CAP_R  = 3'd4;
  localparam logic [2:0] ST_RESP   = 3'd5;

  function automatic logic [1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Brief    : Two-requester round-robin grant; ptr picks the winner on conflict.
// Revision : 1.0
// ============================================================================
module rr_arb2
  import div_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = req;
    if (req == 2'b11) begin
      gnt = idx_to_onehot(ptr);
    end
  end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : div_arbiter
// Brief    : Shares one serial-operand divider between two requesters.
// Revision : 1.0
// ============================================================================
module div_arbiter
  import div_arb_pkg::*;
#(
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF,
  parameter int TW      = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   req,
  input  logic [W-1:0] dividend0,
  input  logic [W-1:0] divisor0,
  input  logic [W-1:0] dividend1,
  input  logic [W-1:0] divisor1,
  output logic [1:0]   resp_valid,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         zero_out,
  output logic         ovf_out,
  output logic         err,
  output logic         busy,
  output logic [W-1:0] div_bus_in,
  output logic         div_start,
  input  logic [W-1:0] div_bus_out,
  input  logic         div_done,
  input  logic         div_zero,
  input  logic         div_ovf
);

  logic [2:0]    state_q, state_d;
  logic          gnt_idx_q, gnt_idx_d;
  logic          ptr_q, ptr_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [W-1:0]  quot_q, quot_d;
  logic [W-1:0]  rem_q, rem_d;
  logic          zero_q, zero_d;
  logic          ovf_q, ovf_d;
  logic          err_q, err_d;
  logic [1:0]    arb_gnt;

  rr_arb2 u_rr_arb2 (
    .req (req),
    .ptr (ptr_q),
    .gnt (arb_gnt)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      gnt_idx_q <= 1'b0;
      ptr_q     <= 1'b0;
      timer_q   <= '0;
      quot_q    <= '0;
      rem_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      timer_q   <= timer_d;
      quot_q    <= quot_d;
      rem_q     <= rem_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    timer_d   = timer_q;
    quot_d    = quot_q;
    rem_d     = rem_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req != 2'b00) begin
          gnt_idx_d = arb_gnt[1];
          state_d   = ST_LOAD_A;
        end
      end
      ST_LOAD_A: state_d = ST_LOAD_B;
      ST_LOAD_B: begin
        timer_d = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        timer_d = timer_q + TW'(1);
        // done wins over a timeout landing in the same cycle
        if (div_done) begin
          quot_d  = div_bus_out;
          zero_d  = div_zero;
          ovf_d   = div_ovf;
          err_d   = 1'b0;
          state_d = ST_CAP_R;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          zero_d  = 1'b0;
          ovf_d   = 1'b0;
          err_d   = 1'b1;
          state_d = ST_RESP;
        end
      end
      ST_CAP_R: begin
        rem_d   = div_bus_out;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        ptr_d   = ~gnt_idx_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_start  = 1'b0;
    div_bus_in = '0;
    resp_valid = 2'b00;
    case (state_q)
      ST_LOAD_A: begin
        div_start  = 1'b1;
        div_bus_in = gnt_idx_q ? dividend1 : dividend0;
      end
      ST_LOAD_B: div_bus_in = gnt_idx_q ? divisor1 : divisor0;
      ST_RESP:   resp_valid = idx_to_onehot(gnt_idx_q);
      default:   ;
    endcase
  end

  assign busy      = (state_q != ST_IDLE);
  assign quotient  = quot_q;
  assign remainder = rem_q;
  assign zero_out  = zero_q;
  assign ovf_out   = ovf_q;
  assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_div_arbiter
// Brief    : Directed scoreboard bench for div_arbiter with a divider model.
// Revision : 1.0
// ============================================================================
module tb_div_arbiter;

  localparam int W = 5;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] dividend0, divisor0, dividend1, divisor1;
  logic [1:0]   resp_valid;
  logic [W-1:0] quotient, remainder;
  logic         zero_out, ovf_out, err, busy;
  logic [W-1:0] div_bus_in;
  logic         div_start;
  logic [W-1:0] div_bus_out;
  logic         div_done, div_zero, div_ovf;

  div_arbiter #(.W(W), .TIMEOUT(31), .TW(5)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .dividend0   (dividend0),
    .divisor0    (divisor0),
    .dividend1   (dividend1),
    .divisor1    (divisor1),
    .resp_valid  (resp_valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .zero_out    (zero_out),
    .ovf_out     (ovf_out),
    .err         (err),
    .busy        (busy),
    .div_bus_in  (div_bus_in),
    .div_start   (div_start),
    .div_bus_out (div_bus_out),
    .div_done    (div_done),
    .div_zero    (div_zero),
    .div_ovf     (div_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { logic [W-1:0] a; logic [W-1:0] b; } op_t;
  typedef struct { logic [W-1:0] q; logic [W-1:0] r; logic z; logic o; int delay; bit never; } cfg_t;
  typedef struct { logic [1:0] valid; logic [W-1:0] q; logic [W-1:0] r; logic z; logic o; logic e; int lat; } resp_t;

  op_t   op_q[$];
  cfg_t  cfg_q[$];
  resp_t exp_q[$];

  int errors = 0, checks = 0;
  int cyc = 0, start_cyc = 0, resp_seen = 0, starts_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Divider stand-in: samples operands, replays the configured result.
  initial begin : divider_model
    op_t          op;
    cfg_t         cfg;
    logic [W-1:0] a_seen;
    div_done = 1'b0; div_bus_out = '0; div_zero = 1'b0; div_ovf = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && div_start) begin
        start_cyc = cyc;
        starts_seen++;
        a_seen = div_bus_in;
        @(negedge clk);
        if (op_q.size() == 0 || cfg_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL model_start: unexpected div_start, bus_in=%0d", a_seen);
        end else begin
          op  = op_q.pop_front();
          cfg = cfg_q.pop_front();
          check("start_dividend", int'(a_seen), int'(op.a));
          check("start_divisor", int'(div_bus_in), int'(op.b));
          check("start_one_cycle", int'(div_start), 0);
          if (!cfg.never) begin
            repeat (cfg.delay - 1) @(negedge clk);
            div_done = 1'b1; div_bus_out = cfg.q; div_zero = cfg.z; div_ovf = cfg.o;
            @(negedge clk);
            div_done = 1'b0; div_bus_out = cfg.r; div_zero = 1'b0; div_ovf = 1'b0;
            @(negedge clk);
            div_bus_out = '0;
          end
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst && resp_valid != 2'b00) begin
        resp_seen++;
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL resp_unexpected: resp_valid=%b with no expected response", resp_valid);
        end else begin
          e = exp_q.pop_front();
          check("resp_valid", int'(resp_valid), int'(e.valid));
          check("quotient", int'(quotient), int'(e.q));
          check("remainder", int'(remainder), int'(e.r));
          check("zero_out", int'(zero_out), int'(e.z));
          check("ovf_out", int'(ovf_out), int'(e.o));
          check("err", int'(err), int'(e.e));
          check("latency_from_start", cyc - start_cyc, e.lat);
        end
      end
    end
  end

  // Normal transaction: done arrives `delay` cycles after start, response 2 later.
  task automatic txn(input logic idx, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic z, input logic o, input int delay);
    op_q.push_back('{a: a, b: b});
    cfg_q.push_back('{q: q, r: r, z: z, o: o, delay: delay, never: 1'b0});
    exp_q.push_back('{valid: (idx ? 2'b10 : 2'b01), q: q, r: r, z: z, o: o, e: 1'b0, lat: delay + 2});
  endtask

  task automatic wait_resps(input int target, input int budget, input string name);
    int n = 0;
    while (resp_seen < target && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    checks++;
    if (resp_seen < target) begin
      errors++;
      $display("FAIL %s: responses seen %0d expected %0d", name, resp_seen, target);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_resp_valid"}, int'(resp_valid), 0);
    check({tag, "_quotient"}, int'(quotient), 0);
    check({tag, "_remainder"}, int'(remainder), 0);
    check({tag, "_flags"}, int'({zero_out, ovf_out, err}), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_div_start"}, int'(div_start), 0);
    check({tag, "_div_bus_in"}, int'(div_bus_in), 0);
  endtask

  initial begin : stimulus
    int n;
    rst = 1'b0; req = 2'b00;
    dividend0 = '0; divisor0 = '0; dividend1 = '0; divisor1 = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    #1 rst = 1'b1;

    // Single request from requester 0
    dividend0 = 5'd13; divisor0 = 5'd4;
    txn(1'b0, 5'd13, 5'd4, 5'd3, 5'd1, 1'b0, 1'b0, 6);
    req = 2'b01;
    wait_resps(1, 40, "t1_wait");
    req = 2'b00;

    // Requester 1, zero quotient; also hands the pointer back to requester 0
    dividend1 = 5'd3; divisor1 = 5'd7;
    txn(1'b1, 5'd3, 5'd7, 5'd0, 5'd3, 1'b1, 1'b0, 3);
    req = 2'b10;
    wait_resps(2, 40, "t2_wait");
    req = 2'b00;

    // Continuous contention: 0, 1, 0
    dividend0 = 5'd20; divisor0 = 5'd3; dividend1 = 5'd9; divisor1 = 5'd9;
    txn(1'b0, 5'd20, 5'd3, 5'd6, 5'd2, 1'b0, 1'b0, 4);
    txn(1'b1, 5'd9,  5'd9, 5'd1, 5'd0, 1'b0, 1'b0, 4);
    txn(1'b0, 5'd20, 5'd3, 5'd6, 5'd2, 1'b0, 1'b0, 4);
    req = 2'b11;
    wait_resps(5, 80, "t3_wait");
    req = 2'b00;

    // Divide by zero, done in the first WAIT cycle (minimum latency)
    dividend0 = 5'd10; divisor0 = 5'd0;
    txn(1'b0, 5'd10, 5'd0, 5'd31, 5'd10, 1'b0, 1'b1, 2);
    req = 2'b01;
    wait_resps(6, 40, "t4_wait");
    req = 2'b00;

    // Divider never finishes: timeout response
    dividend1 = 5'd17; divisor1 = 5'd2;
    op_q.push_back('{a: 5'd17, b: 5'd2});
    cfg_q.push_back('{q: 5'd0, r: 5'd0, z: 1'b0, o: 1'b0, delay: 0, never: 1'b1});
    exp_q.push_back('{valid: 2'b10, q: 5'd0, r: 5'd0, z: 1'b0, o: 1'b0, e: 1'b1, lat: 33});
    req = 2'b10;
    wait_resps(7, 60, "t5_wait");
    req = 2'b00;

    // Normal service after a timeout
    dividend0 = 5'd31; divisor0 = 5'd5;
    txn(1'b0, 5'd31, 5'd5, 5'd6, 5'd1, 1'b0, 1'b0, 4);
    req = 2'b01;
    wait_resps(8, 40, "t6_wait");
    req = 2'b00;

    // Reset while waiting on the divider
    dividend0 = 5'd12; divisor0 = 5'd5;
    op_q.push_back('{a: 5'd12, b: 5'd5});
    cfg_q.push_back('{q: 5'd0, r: 5'd0, z: 1'b0, o: 1'b0, delay: 0, never: 1'b1});
    req = 2'b01;
    n = 0;
    while (starts_seen < 9 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    check("t7_start_seen", starts_seen, 9);
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1 check_quiet("midreset");
    req = 2'b00;
    @(negedge clk); #1 rst = 1'b1;
    repeat (5) @(negedge clk);
    check("t7_no_resp", resp_seen, 8);

    // Pointer must be back at requester 0
    #1;
    dividend0 = 5'd7; divisor0 = 5'd2; dividend1 = 5'd1; divisor1 = 5'd1;
    txn(1'b0, 5'd7, 5'd2, 5'd3, 5'd1, 1'b0, 1'b0, 5);
    req = 2'b11;
    wait_resps(9, 40, "t8_wait");
    req = 2'b00;

    repeat (6) @(negedge clk);
    check("exp_queue_drained", exp_q.size(), 0);
    check("op_queue_drained", op_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
